// File: rtl/div_issue_queue.sv
// ---------------------------------------------------------------------------
// div_issue_queue
//
// Front-end and result collector for a fixed-latency pipelined signed divider.
// Requests are passed straight through to the divider. Each request's tag and
// divide-by-zero flag travel alongside it in a LATENCY-deep shift pipe. When
// the pipe head is valid, the divider result is written into a DEPTH-entry
// result FIFO. A credit count (requests in flight plus entries buffered)
// throttles acceptance so the FIFO can never overflow. This is needed because
// the divider has no backpressure.
//
// Optional feature (macro SYNC_CHECK_EN):
//   defined   : sync_error_out is a sticky flag. It is set whenever the
//               divider's valid output disagrees with the tag pipe head.
//               Only rst_in clears it.
//   undefined : sync_error_out is tied low and no compare logic is built.
//
// Handshakes: a transfer happens on a rising clk_in edge when valid and ready
// are both high. Valid never depends on ready on the producing side.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   req_*                request channel from the solver (valid/ready)
//   div_*_out            operands and valid into the divider
//   div_*_in             quotient, remainder and valid from the divider
//   res_*                result channel to the consumer (valid/ready)
//   busy_out             any request in flight or buffered
//   sync_error_out       sticky pipe/divider mismatch (SYNC_CHECK_EN only)
// ---------------------------------------------------------------------------
module div_issue_queue #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 8,
    parameter int LATENCY = 16,
    parameter int DEPTH   = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [WIDTH-1:0] req_dividend_in,
    input  logic [WIDTH-1:0] req_divisor_in,
    input  logic [TAG_W-1:0] req_tag_in,
    output logic [WIDTH-1:0] div_dividend_out,
    output logic [WIDTH-1:0] div_divisor_out,
    output logic             div_valid_out,
    input  logic [WIDTH-1:0] div_quotient_in,
    input  logic [WIDTH-1:0] div_remainder_in,
    input  logic             div_valid_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] res_quotient_out,
    output logic [WIDTH-1:0] res_remainder_out,
    output logic [TAG_W-1:0] res_tag_out,
    output logic             res_div_zero_out,
    output logic             busy_out,
    output logic             sync_error_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] quot;
        logic [WIDTH-1:0] rem;
        logic [TAG_W-1:0] tag;
        logic             zero;
    } res_t;

    // Tag pipe. Index 0 is loaded on issue, and index LATENCY-1 is the head
    // that lines up with div_valid_in.
    logic [LATENCY-1:0]            pipe_valid_q, pipe_valid_d;
    logic [LATENCY-1:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;
    logic [LATENCY-1:0]            pipe_zero_q, pipe_zero_d;

    // Result FIFO storage and bookkeeping.
    res_t [DEPTH-1:0] fifo_mem_q, fifo_mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;

    logic [CNT_W:0] outstanding;
    logic           issue;
    logic           head_valid;
    logic           capture;
    logic           pop;
    res_t           cap_entry;
    res_t           head_entry;

    // Issue side and credit check.
    always_comb begin
        outstanding      = {1'b0, in_flight_q} + {1'b0, fifo_count_q};
        // Holding ready low during reset stops a request from being taken
        // while the bookkeeping is being cleared.
        req_ready_out    = ~rst_in & (outstanding < DEPTH_C);
        issue            = req_valid_in & req_ready_out;
        div_dividend_out = req_dividend_in;
        div_divisor_out  = req_divisor_in;
        div_valid_out    = issue;
        busy_out         = (outstanding != '0);
    end

    // Tag pipe shift. A zero divisor is still issued so that results stay in
    // order; the flag rides along and patches the result on capture.
    always_comb begin
        pipe_valid_d    = '0;
        pipe_tag_d      = '0;
        pipe_zero_d     = '0;
        pipe_valid_d[0] = issue;
        pipe_tag_d[0]   = req_tag_in;
        pipe_zero_d[0]  = (req_divisor_in == '0);
        for (int i = 1; i < LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_tag_d[i]   = pipe_tag_q[i-1];
            pipe_zero_d[i]  = pipe_zero_q[i-1];
        end
    end

    // Capture into the FIFO. The credit check guarantees space, so the write
    // is not qualified by a full flag.
    always_comb begin
        head_valid     = pipe_valid_q[LATENCY-1];
        capture        = head_valid;
        cap_entry.tag  = pipe_tag_q[LATENCY-1];
        cap_entry.zero = pipe_zero_q[LATENCY-1];
        if (pipe_zero_q[LATENCY-1]) begin
            cap_entry.quot = '1;
            cap_entry.rem  = '0;
        end else begin
            cap_entry.quot = div_quotient_in;
            cap_entry.rem  = div_remainder_in;
        end

        fifo_mem_d = fifo_mem_q;
        if (capture) begin
            fifo_mem_d[wr_ptr_q] = cap_entry;
        end
    end

    // FIFO read side. The data outputs are held at zero while the FIFO is
    // empty, so stale entries are never shown.
    always_comb begin
        head_entry        = fifo_mem_q[rd_ptr_q];
        res_valid_out     = (fifo_count_q != '0);
        pop               = res_valid_out & res_ready_in;
        res_quotient_out  = res_valid_out ? head_entry.quot : '0;
        res_remainder_out = res_valid_out ? head_entry.rem  : '0;
        res_tag_out       = res_valid_out ? head_entry.tag  : '0;
        res_div_zero_out  = res_valid_out & head_entry.zero;
    end

    // Pointers wrap naturally because DEPTH is a power of two. A request
    // moves from in_flight to fifo_count on capture, so an accept and a pop
    // in the same cycle leave the credit total unchanged.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(capture);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        in_flight_d  = in_flight_q + CNT_W'(issue) - CNT_W'(capture);
        fifo_count_d = fifo_count_q + CNT_W'(capture) - CNT_W'(pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pipe_valid_q <= '0;
            pipe_tag_q   <= '0;
            pipe_zero_q  <= '0;
            fifo_mem_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            in_flight_q  <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
            pipe_zero_q  <= pipe_zero_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            in_flight_q  <= in_flight_d;
        end
    end

`ifdef SYNC_CHECK_EN
    logic sync_error_q, sync_error_d;

    // A divider result arriving with no pipe entry (for example, stale work
    // after a reset), or a pipe entry with no result, means the divider build
    // and LATENCY disagree.
    always_comb begin
        sync_error_d = sync_error_q | (div_valid_in != head_valid);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_error_q <= 1'b0;
        end else begin
            sync_error_q <= sync_error_d;
        end
    end

    assign sync_error_out = sync_error_q;
`else
    // Without the checker, the divider's valid output carries no information
    // this block needs. Capture timing comes entirely from the tag pipe.
    logic div_valid_unused;
    assign div_valid_unused = div_valid_in;
    assign sync_error_out   = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_queue.sv
// ---------------------------------------------------------------------------
// Testbench for div_issue_queue.
// Main instance: LATENCY=16, DEPTH=8. Second instance: LATENCY=2, DEPTH=4,
// used for the back-to-back throughput run.
// Each divider is modelled as a fixed-latency pipe of ideal results.
// The reference model keeps, per accepted request, its expected result and
// the cycle from which it must be visible.
// ---------------------------------------------------------------------------
module tb_div_issue_queue;

    localparam int W      = 32;
    localparam int TW     = 8;
    localparam int LAT    = 16;
    localparam int DEPTH  = 8;
    localparam int LAT2   = 2;
    localparam int DEPTH2 = 4;
`ifdef SYNC_CHECK_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT signals ----------------
    logic          req_valid, req_ready_out;
    logic [W-1:0]  req_dividend, req_divisor;
    logic [TW-1:0] req_tag;
    logic [W-1:0]  div_dividend_out, div_divisor_out;
    logic          div_valid_out;
    logic [W-1:0]  div_quotient_in, div_remainder_in;
    logic          div_valid_in;
    logic          res_valid_out, res_ready;
    logic [W-1:0]  res_quotient_out, res_remainder_out;
    logic [TW-1:0] res_tag_out;
    logic          res_div_zero_out, busy_out, sync_error_out;

    // ---------------- throughput DUT signals ----------------
    logic          r2_valid, r2_ready_out;
    logic [W-1:0]  r2_dividend, r2_divisor;
    logic [TW-1:0] r2_tag;
    logic [W-1:0]  d2_dividend_out, d2_divisor_out;
    logic          d2_valid_out;
    logic [W-1:0]  d2_quotient_in, d2_remainder_in;
    logic          d2_valid_in;
    logic          s2_valid_out, s2_ready;
    logic [W-1:0]  s2_quotient_out, s2_remainder_out;
    logic [TW-1:0] s2_tag_out;
    logic          s2_div_zero_out, s2_busy_out, s2_sync_error_out;

    div_issue_queue #(.WIDTH(W), .TAG_W(TW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(req_valid), .req_ready_out(req_ready_out),
        .req_dividend_in(req_dividend), .req_divisor_in(req_divisor), .req_tag_in(req_tag),
        .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
        .div_valid_out(div_valid_out),
        .div_quotient_in(div_quotient_in), .div_remainder_in(div_remainder_in),
        .div_valid_in(div_valid_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready),
        .res_quotient_out(res_quotient_out), .res_remainder_out(res_remainder_out),
        .res_tag_out(res_tag_out), .res_div_zero_out(res_div_zero_out),
        .busy_out(busy_out), .sync_error_out(sync_error_out)
    );

    div_issue_queue #(.WIDTH(W), .TAG_W(TW), .LATENCY(LAT2), .DEPTH(DEPTH2)) dut2 (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(r2_valid), .req_ready_out(r2_ready_out),
        .req_dividend_in(r2_dividend), .req_divisor_in(r2_divisor), .req_tag_in(r2_tag),
        .div_dividend_out(d2_dividend_out), .div_divisor_out(d2_divisor_out),
        .div_valid_out(d2_valid_out),
        .div_quotient_in(d2_quotient_in), .div_remainder_in(d2_remainder_in),
        .div_valid_in(d2_valid_in),
        .res_valid_out(s2_valid_out), .res_ready_in(s2_ready),
        .res_quotient_out(s2_quotient_out), .res_remainder_out(s2_remainder_out),
        .res_tag_out(s2_tag_out), .res_div_zero_out(s2_div_zero_out),
        .busy_out(s2_busy_out), .sync_error_out(s2_sync_error_out)
    );

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ideal signed divider: truncating quotient, magnitude remainder. A zero
    // divisor yields deliberately meaningless data (quotient 0, remainder a).
    function automatic logic [63:0] div_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, ma, mb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return {32'h0, a};
        q  = sa / sb;
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        r  = ma % mb;
        return {q[31:0], r[31:0]};
    endfunction

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic          z;
        int            avail;
    } exp_t;

    function automatic exp_t mk_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [TW-1:0] t, input int avail);
        exp_t e;
        logic [63:0] qr;
        qr      = div_fn(a, b);
        e.z     = (b == '0);
        e.q     = e.z ? 32'hFFFF_FFFF : qr[63:32];
        e.r     = e.z ? 32'h0 : qr[31:0];
        e.tag   = t;
        e.avail = avail;
        return e;
    endfunction

    // ---------------- divider models ----------------
    logic [LAT-1:0]        dm_v = '0;
    logic [LAT-1:0][63:0]  dm_qr = '0;
    always @(posedge clk) begin
        dm_v  <= {dm_v[LAT-2:0], div_valid_out};
        dm_qr <= {dm_qr[LAT-2:0], div_fn(div_dividend_out, div_divisor_out)};
    end
    assign div_valid_in     = dm_v[LAT-1];
    assign div_quotient_in  = dm_qr[LAT-1][63:32];
    assign div_remainder_in = dm_qr[LAT-1][31:0];

    logic [LAT2-1:0]       dm2_v = '0;
    logic [LAT2-1:0][63:0] dm2_qr = '0;
    always @(posedge clk) begin
        dm2_v  <= {dm2_v[LAT2-2:0], d2_valid_out};
        dm2_qr <= {dm2_qr[LAT2-2:0], div_fn(d2_dividend_out, d2_divisor_out)};
    end
    assign d2_valid_in     = dm2_v[LAT2-1];
    assign d2_quotient_in  = dm2_qr[LAT2-1][63:32];
    assign d2_remainder_in = dm2_qr[LAT2-1][31:0];

    // ---------------- reference model + compare (main) ----------------
    exp_t exp_q[$];
    bit   exp_sync = 1'b0;
    bit   mon_en   = 1'b0;

    always @(negedge clk) begin
        bit exp_ready, exp_valid, head_due;
        if (rst) begin
            exp_q.delete();
            exp_sync = 1'b0;
            chk("rst_ready", req_ready_out, 1'b0);
        end else if (mon_en) begin
            exp_ready = (exp_q.size() < DEPTH);
            exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            chk("req_ready", req_ready_out, exp_ready);
            chk("div_valid", div_valid_out, req_valid & exp_ready);
            chk("div_dividend", div_dividend_out, req_dividend);
            chk("div_divisor", div_divisor_out, req_divisor);
            chk("busy", busy_out, exp_q.size() != 0);
            chk("res_valid", res_valid_out, exp_valid);
            chk("sync_error", sync_error_out, exp_sync);
            if (exp_valid) begin
                chk("res_quot", res_quotient_out, exp_q[0].q);
                chk("res_rem", res_remainder_out, exp_q[0].r);
                chk("res_tag", res_tag_out, exp_q[0].tag);
                chk("res_zero", res_div_zero_out, exp_q[0].z);
            end
            head_due = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].avail - 1 == cyc) head_due = 1'b1;
            if (SYNC_ON && (div_valid_in != head_due)) exp_sync = 1'b1;
            if (exp_valid && res_ready) void'(exp_q.pop_front());
            if (req_valid && exp_ready)
                exp_q.push_back(mk_exp(req_dividend, req_divisor, req_tag, cyc + LAT + 1));
        end
    end

    // ---------------- reference model + compare (throughput) ----------------
    exp_t e2_q[$];
    always @(negedge clk) begin
        bit e2_ready, e2_valid;
        if (rst) begin
            e2_q.delete();
        end else if (mon_en) begin
            e2_ready = (e2_q.size() < DEPTH2);
            e2_valid = (e2_q.size() > 0) && (e2_q[0].avail <= cyc);
            chk("q2_ready", r2_ready_out, e2_ready);
            chk("q2_valid", s2_valid_out, e2_valid);
            chk("q2_busy", s2_busy_out, e2_q.size() != 0);
            if (e2_valid) begin
                chk("q2_quot", s2_quotient_out, e2_q[0].q);
                chk("q2_tag", s2_tag_out, e2_q[0].tag);
            end
            if (e2_valid && s2_ready) void'(e2_q.pop_front());
            if (r2_valid && e2_ready)
                e2_q.push_back(mk_exp(r2_dividend, r2_divisor, r2_tag, cyc + LAT2 + 1));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, output int acc_cyc);
        bit done;
        done         = 1'b0;
        acc_cyc      = -1;
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        req_tag      = t;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready_out) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        req_valid = 1'b0;
        chk("send_accepted", done, 1'b1);
    endtask

    task automatic expect_res(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic [TW-1:0] t, input logic z, output int got);
        bit seen;
        seen = 1'b0;
        got  = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (res_valid_out) begin
                seen = 1'b1;
                got  = cyc;
                chk("lit_quot", res_quotient_out, q);
                chk("lit_rem", res_remainder_out, r);
                chk("lit_tag", res_tag_out, t);
                chk("lit_zero", res_div_zero_out, z);
            end
            @(posedge clk); #1;
            if (seen) break;
        end
        chk("lit_seen", seen, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, got, n_acc, n_got, n2, sel;
        logic [W-1:0] tmp;
        bit seen;

        rst = 1'b1;
        req_valid = 1'b0; req_dividend = '0; req_divisor = '0; req_tag = '0; res_ready = 1'b0;
        r2_valid = 1'b0; r2_dividend = '0; r2_divisor = '0; r2_tag = '0; s2_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", req_ready_out, 1'b1);
        chk("reset_res_valid", res_valid_out, 1'b0);
        chk("reset_busy", busy_out, 1'b0);
        chk("reset_sync", sync_error_out, 1'b0);
        chk("reset_quot", res_quotient_out, 32'h0);
        chk("reset_tag", res_tag_out, 8'h0);
        @(posedge clk); #1;

        // Directed results with the consumer always ready.
        res_ready = 1'b1;
        send(32'd100, 32'd7, 8'h11, acc);
        expect_res(32'd14, 32'd2, 8'h11, 1'b0, got);
        chk("latency", got - acc, LAT + 1);
        send(32'hFFFF_FF9C, 32'd7, 8'h22, acc);
        expect_res(32'hFFFF_FFF2, 32'd2, 8'h22, 1'b0, got);
        send(32'd5, 32'd0, 8'h33, acc);
        send(32'd9, 32'd3, 8'h34, acc);
        expect_res(32'hFFFF_FFFF, 32'd0, 8'h33, 1'b1, got);
        expect_res(32'd3, 32'd0, 8'h34, 1'b0, got);
        repeat (4) begin @(posedge clk); #1; end

        // Consumer stalled: credits must stop acceptance at DEPTH.
        res_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 40; k++) begin
            req_valid    = 1'b1;
            req_dividend = 32'd1000 + 32'(n_acc);
            req_divisor  = 32'd7;
            req_tag      = 8'h40 + 8'(n_acc);
            @(negedge clk);
            if (req_ready_out) n_acc++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_accepted", n_acc, DEPTH);
        @(negedge clk);
        chk("bp_ready_low", req_ready_out, 1'b0);
        chk("bp_busy", busy_out, 1'b1);
        chk("bp_valid", res_valid_out, 1'b1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        n_got = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (res_valid_out) begin
                chk("bp_tag", res_tag_out, 8'h40 + 8'(n_got));
                chk("bp_quot", res_quotient_out, (1000 + n_got) / 7);
                n_got++;
            end
            @(posedge clk); #1;
        end
        chk("bp_drained", n_got, DEPTH);
        @(negedge clk);
        chk("bp_idle", busy_out, 1'b0);
        @(posedge clk); #1;

        // Reset while five requests are still inside the divider.
        for (int i = 0; i < 5; i++) send(32'(200 + 3 * i), 32'(3 + i), 8'h50 + 8'(i), acc);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < LAT + 6; k++) begin
            @(negedge clk);
            if (res_valid_out) seen = 1'b1;
            chk("rst_mid_busy", busy_out, 1'b0);
            @(posedge clk); #1;
        end
        chk("rst_mid_no_result", seen, 1'b0);
        chk("rst_mid_sync", sync_error_out, SYNC_ON);

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                req_divisor = '0;
            end else if (sel < 5) begin
                tmp = $urandom_range(1, 20);
                req_divisor = $urandom_range(0, 1) ? (32'd0 - tmp) : tmp;
            end else begin
                req_divisor = $urandom;
            end
            req_dividend = $urandom_range(0, 1) ? $urandom : ($urandom_range(0, 2000) - 32'd1000);
            req_tag   = 8'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        repeat (LAT + DEPTH + 5) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rand_drained", busy_out, 1'b0);
        @(posedge clk); #1;

        // Back-to-back issue and pop on the short-latency instance.
        s2_ready = 1'b1;
        n2 = 0;
        for (int k = 0; k < 43; k++) begin
            r2_valid    = (k < 40);
            r2_dividend = $urandom;
            r2_divisor  = $urandom_range(1, 50);
            r2_tag      = 8'(k);
            @(negedge clk);
            if (k < 40) chk("tp_ready", r2_ready_out, 1'b1);
            if (s2_valid_out) n2++;
            @(posedge clk); #1;
        end
        r2_valid = 1'b0;
        chk("tp_results", n2, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
